// File: rtl/fp_recip_issue_buffer_pkg.sv
// Shared types for the reciprocal issue/result buffer.
//   fp_32b_t    : raw IEEE-754 single-precision word
//   fp_flags_t  : exception flags {nv, of, uf, nx}, nv in the MSB
//   fp_result_t : one buffered pipeline result (value + flags)
package fp_recip_issue_buffer_pkg;

  typedef logic [31:0] fp_32b_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  typedef struct packed {
    fp_32b_t   value;
    fp_flags_t flags;
  } fp_result_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Result FIFO with show-ahead head and synchronously reset storage.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   push, wdata: write wdata at the write pointer (caller guarantees a slot)
//   pop        : advance the read pointer (caller guarantees non-empty)
//   full, empty: occupancy status
//   count      : occupancy, $clog2(DEPTH)+1 bits
//   head       : entry at the read pointer
module fp_result_fifo
  import fp_recip_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fp_result_t                 wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fp_result_t                 head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fp_result_t       mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;

  // Push while full is legal when a pop happens in the same cycle: the slot
  // being written is the one being vacated.
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/fp_recip_issue_buffer.sv
// Issue and result buffer around the non-stallable FP reciprocal pipeline.
// Operands pass straight through to the pipeline; a credit counter (inflight
// + FIFO occupancy) keeps issue closed unless every in-flight result is
// guaranteed a FIFO slot. Results are buffered and returned with sticky
// fflags accumulation and a sticky overrun error.
// Ports:
//   clk, rst_n                          : clock, synchronous active-low reset
//   issue_valid/ready, issue_data/rm    : operand handshake from the issuer
//   pipe_valid_in, pipe_in, pipe_rm     : to the pipeline (combinational)
//   pipe_valid_out, pipe_out, pipe_flags: from the pipeline
//   res_valid/ready, res_data/flags     : result handshake to the consumer
//   fflags, fflags_clr                  : sticky flag accumulator and clear
//   err_overrun                         : sticky, a return was dropped
module fp_recip_issue_buffer
  import fp_recip_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [31:0] issue_data,
  input  logic [2:0]  issue_rm,
  output logic        issue_ready,
  output logic        pipe_valid_in,
  output logic [31:0] pipe_in,
  output logic [2:0]  pipe_rm,
  input  logic        pipe_valid_out,
  input  logic [31:0] pipe_out,
  input  logic [3:0]  pipe_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_flags,
  output logic [3:0]  fflags,
  input  logic        fflags_clr,
  output logic        err_overrun
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [3:0]    fflags_q, fflags_d;
  logic          err_q, err_d;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fp_result_t    fifo_head, fifo_wdata;

  logic          issue_fire, pop, accept;
  logic [CW:0]   credit_sum;

  // One extra bit so inflight + count cannot wrap.
  assign credit_sum  = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue_ready = (credit_sum < DepthW);
  assign issue_fire  = issue_valid & issue_ready;

  assign pipe_valid_in = issue_fire;
  assign pipe_in       = issue_data;
  assign pipe_rm       = issue_rm;

  assign res_valid = ~fifo_empty;
  assign pop       = res_valid & res_ready;

  // A return with no outstanding credit, or with no slot even after this
  // cycle's pop, is dropped and flagged.
  assign accept = pipe_valid_out & (inflight_q != '0) & (~fifo_full | pop);

  assign fifo_wdata = '{value: pipe_out, flags: pipe_flags};

  fp_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (fifo_wdata),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign res_data  = fifo_head.value;
  assign res_flags = fifo_head.flags;

  always_comb begin
    inflight_d = inflight_q + CW'(issue_fire) - CW'(accept);
    // Clear applies to the old value only, so flags arriving this cycle survive.
    fflags_d   = (fflags_clr ? 4'b0 : fflags_q) | (accept ? pipe_flags : 4'b0);
    err_d      = err_q | (pipe_valid_out & ~accept);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
      fflags_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      fflags_q   <= fflags_d;
      err_q      <= err_d;
    end
  end

  assign fflags      = fflags_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_fp_recip_issue_buffer.sv
// Directed bench for fp_recip_issue_buffer (DEPTH = 4). The bench plays the
// role of the reciprocal pipeline, returning hand-computed results.
module tb_fp_recip_issue_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [31:0] issue_data;
  logic [2:0]  issue_rm;
  logic        issue_ready;
  logic        pipe_valid_in;
  logic [31:0] pipe_in;
  logic [2:0]  pipe_rm;
  logic        pipe_valid_out;
  logic [31:0] pipe_out;
  logic [3:0]  pipe_flags;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic [3:0]  fflags;
  logic        fflags_clr;
  logic        err_overrun;

  int n_cmp = 0;
  int n_err = 0;
  int accepted;

  always #5 clk = ~clk;

  fp_recip_issue_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_data     (issue_data),
    .issue_rm       (issue_rm),
    .issue_ready    (issue_ready),
    .pipe_valid_in  (pipe_valid_in),
    .pipe_in        (pipe_in),
    .pipe_rm        (pipe_rm),
    .pipe_valid_out (pipe_valid_out),
    .pipe_out       (pipe_out),
    .pipe_flags     (pipe_flags),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_flags      (res_flags),
    .fflags         (fflags),
    .fflags_clr     (fflags_clr),
    .err_overrun    (err_overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic [2:0] rm);
    issue_valid = 1'b1;
    issue_data  = d;
    issue_rm    = rm;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic ret(input logic [31:0] d, input logic [3:0] f, input logic clr);
    pipe_valid_out = 1'b1;
    pipe_out       = d;
    pipe_flags     = f;
    fflags_clr     = clr;
    tick();
    pipe_valid_out = 1'b0;
    fflags_clr     = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] d, input logic [3:0] f);
    check_eq({tag, "_valid"}, 32'(res_valid), 32'd1);
    check_eq({tag, "_data"}, res_data, d);
    check_eq({tag, "_flags"}, 32'(res_flags), 32'(f));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_data = '0; issue_rm = '0;
    pipe_valid_out = 1'b0; pipe_out = '0; pipe_flags = '0;
    res_ready = 1'b0; fflags_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_issue_ready", 32'(issue_ready), 32'd1);
    check_eq("rst_pipe_valid_in", 32'(pipe_valid_in), 32'd0);
    check_eq("rst_res_data", res_data, 32'h0);
    check_eq("rst_res_flags", 32'(res_flags), 32'd0);
    check_eq("rst_fflags", 32'(fflags), 32'd0);
    check_eq("rst_err", 32'(err_overrun), 32'd0);

    // Round trip: 1/2.0 = 0.5, exact
    issue_valid = 1'b1; issue_data = 32'h4000_0000; issue_rm = 3'b000;
    #1;
    check_eq("rt_pvi", 32'(pipe_valid_in), 32'd1);
    check_eq("rt_pipe_in", pipe_in, 32'h4000_0000);
    check_eq("rt_pipe_rm", 32'(pipe_rm), 32'd0);
    tick();
    issue_valid = 1'b0;
    #1;
    check_eq("rt_pvi_idle", 32'(pipe_valid_in), 32'd0);
    tick();
    pipe_valid_out = 1'b1; pipe_out = 32'h3F00_0000; pipe_flags = 4'b0000;
    #1;
    check_eq("rt_no_bypass", 32'(res_valid), 32'd0);
    tick();
    pipe_valid_out = 1'b0;
    pop_chk("rt", 32'h3F00_0000, 4'b0000);
    check_eq("rt_fflags", 32'(fflags), 32'd0);
    check_eq("rt_empty", 32'(res_valid), 32'd0);
    check_eq("rt_err", 32'(err_overrun), 32'd0);

    // sNaN: quieted payload with invalid flag; sticky across clean results
    issue_valid = 1'b1; issue_data = 32'h7F80_0001; issue_rm = 3'b011;
    #1;
    check_eq("snan_pipe_rm", 32'(pipe_rm), 32'd3);
    tick();
    issue_valid = 1'b0;
    ret(32'h7FC0_0001, 4'b1000, 1'b0);
    pop_chk("snan", 32'h7FC0_0001, 4'b1000);
    check_eq("snan_fflags", 32'(fflags), 32'h8);
    issue(32'h4000_0000, 3'b000);
    ret(32'h3F00_0000, 4'b0000, 1'b0);
    pop_chk("clean", 32'h3F00_0000, 4'b0000);
    check_eq("snan_sticky", 32'(fflags), 32'h8);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    check_eq("clr_fflags", 32'(fflags), 32'd0);

    // Backpressure: exactly DEPTH issues accepted
    res_ready = 1'b0;
    issue_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      issue_data = 32'h3F80_0000 + 32'(i);
      if (issue_ready) accepted++;
      tick();
    end
    issue_valid = 1'b0;
    check_eq("bp_accepted", 32'(accepted), 32'd4);
    check_eq("bp_closed", 32'(issue_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      ret(32'hA000_0000 + 32'(k), 4'b0000, 1'b0);
    end
    check_eq("bp_full_valid", 32'(res_valid), 32'd1);
    check_eq("bp_full_closed", 32'(issue_ready), 32'd0);
    check_eq("bp_no_err", 32'(err_overrun), 32'd0);
    check_eq("bp_head0", res_data, 32'hA000_0000);
    res_ready = 1'b1;
    #1;
    check_eq("bp_ready_same_cycle", 32'(issue_ready), 32'd0);
    tick();
    res_ready = 1'b0;
    check_eq("bp_reopen", 32'(issue_ready), 32'd1);
    pop_chk("bp_d1", 32'hA000_0001, 4'b0000);

    // count = 2, inflight = 0: issue one, then issue + return + pop together
    issue(32'h4080_0000, 3'b000);
    issue_valid = 1'b1; issue_data = 32'h4080_0000;
    pipe_valid_out = 1'b1; pipe_out = 32'hA000_0004; pipe_flags = 4'b0000;
    res_ready = 1'b1;
    #1;
    check_eq("sim_head", res_data, 32'hA000_0002);
    check_eq("sim_pvi", 32'(pipe_valid_in), 32'd1);
    tick();
    issue_valid = 1'b0; pipe_valid_out = 1'b0; res_ready = 1'b0;
    check_eq("sim_err", 32'(err_overrun), 32'd0);
    check_eq("sim_ready", 32'(issue_ready), 32'd1);
    pop_chk("sim_d3", 32'hA000_0003, 4'b0000);
    pop_chk("sim_d4", 32'hA000_0004, 4'b0000);
    check_eq("sim_drained", 32'(res_valid), 32'd0);
    // inflight must still be 1: this return is accepted
    ret(32'h3E80_0000, 4'b0001, 1'b0);
    check_eq("sim_inflight_ret_err", 32'(err_overrun), 32'd0);
    check_eq("sim_inflight_ret_data", res_data, 32'h3E80_0000);
    check_eq("sim_fflags", 32'(fflags), 32'h1);

    // Clear coinciding with an accepted return
    issue(32'h3F80_0000, 3'b000);
    ret(32'h3F80_0000, 4'b0100, 1'b1);
    check_eq("race_fflags", 32'(fflags), 32'h4);
    check_eq("race_err", 32'(err_overrun), 32'd0);

    // Overrun: return with inflight = 0 (count = 2)
    ret(32'hDEAD_BEEF, 4'b0010, 1'b0);
    check_eq("ovr_err", 32'(err_overrun), 32'd1);
    check_eq("ovr_fflags", 32'(fflags), 32'h4);
    check_eq("ovr_head", res_data, 32'h3E80_0000);
    issue(32'h4000_0000, 3'b000);
    ret(32'h3F00_0000, 4'b0000, 1'b0);
    // count = 3 only if the dropped return left count unchanged
    check_eq("ovr_count", 32'(issue_ready), 32'd1);
    check_eq("ovr_err_sticky", 32'(err_overrun), 32'd1);

    // Reset with count = 3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst2_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst2_issue_ready", 32'(issue_ready), 32'd1);
    check_eq("rst2_err", 32'(err_overrun), 32'd0);
    check_eq("rst2_fflags", 32'(fflags), 32'd0);
    check_eq("rst2_res_data", res_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
